mips_regfile_sb: RTL and testbench
==================================

Name: mips_regfile_sb

Overview:
- Parametrised successor to the single-write-port MIPS register file.
- Adds:
  - a second write port (load writeback alongside ALU writeback),
  - write-through bypass on both read ports,
  - a per-register pending scoreboard for RAW hazard detection,
  - a sticky-free conflict indicator.
- Sits between decode (reads, issue marking) and the two writeback stages of the pipeline.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers.
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes, and is never pending.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears every register and pending bit.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_addr_b  input  ADDR_W  read port B address.
- rd_data_a  output  DATA_W  read port A data, combinational with bypass.
- rd_data_b  output  DATA_W  read port B data, combinational with bypass.
- rd_busy_a  output  1  register at rd_addr_a still awaits writeback.
- rd_busy_b  output  1  register at rd_addr_b still awaits writeback.
- wr0_en  input  1  ALU writeback enable.
- wr0_addr  input  ADDR_W  ALU writeback address.
- wr0_data  input  DATA_W  ALU writeback data.
- wr1_en  input  1  load writeback enable.
- wr1_addr  input  ADDR_W  load writeback address.
- wr1_data  input  DATA_W  load writeback data.
- iss_en  input  1  an instruction issues that will write iss_addr.
- iss_addr  input  ADDR_W  destination register of the issuing instruction.
- flush  input  1  pipeline flush; clears all pending bits.
- pending_cnt  output  ADDR_W+1  number of registers currently pending (combinational popcount).
- wr_conflict  output  1  registered one-cycle pulse: both write ports targeted the same register.

Behaviour:
- Reset (reset=0, asynchronous):
  - all NREG registers = 0; all pending bits = 0; wr_conflict = 0.
  - Outputs immediately: rd_data_* = 0, rd_busy_* = 0, pending_cnt = 0.
  - Reset asserted mid-operation discards any in-flight write or issue that cycle.
- Write (rising edge):
  - wr0_en writes wr0_data to wr0_addr; wr1_en writes wr1_data to wr1_addr.
  - Both enabled, same address: wr1 wins.
  - Address 0 with ZERO_REG=1: write dropped, no effect.
- Read (combinational, zero latency):
  - Priority order:
    1. addr==0 and ZERO_REG=1 -> 0.
    2. wr1_en && wr1_addr==addr -> wr1_data.
    3. wr0_en && wr0_addr==addr -> wr0_data.
    4. Otherwise -> stored value.
  - A same-cycle writeback is therefore visible to the reader without waiting a cycle.
- Scoreboard, per register r, next-state priority at rising edge:
  1. flush=1 -> pending[r] = 0 for all r; iss_en is ignored that cycle.
  2. iss_en && iss_addr==r (r!=0 when ZERO_REG=1) -> pending[r] = 1. A set wins over a same-cycle writeback clear, because the issue is younger.
  3. Any enabled write port targets r -> pending[r] = 0.
  4. Otherwise hold.
- Busy:
  - rd_busy_x = pending[rd_addr_x] && no enabled write port targets rd_addr_x this cycle.
  - Forced 0 for address 0 when ZERO_REG=1.
- pending_cnt:
  - popcount of the pending vector; range 0..NREG; no wrap.
  - Bit 0 contributes nothing when ZERO_REG=1.
- wr_conflict:
  - Registered one cycle after wr0_en && wr1_en && wr0_addr==wr1_addr && address not hardwired zero.
  - High for exactly one cycle per offending cycle; back-to-back conflicts keep it high.
- Reading and writing the same register in one cycle never returns stale data on either read port.

Test Plan:
- Reset values:
  - Assert reset=0 mid-run with r5=0xDEADBEEF and r5 pending -> rd_data_a(5)=0, rd_busy_a=0, pending_cnt=0 without waiting for a clock edge.
- Bypass, single port:
  - wr0_en=1, wr0_addr=7, wr0_data=0x12345678, rd_addr_a=7 in the same cycle -> rd_data_a=0x12345678 before the edge.
  - After the edge with wr0_en=0 -> still 0x12345678.
- Dual-write collision:
  - wr0 (addr 3, 0x11) and wr1 (addr 3, 0x22) in the same cycle -> rd_data_b(3)=0x22 combinationally and after the edge.
  - wr_conflict=1 for exactly one cycle.
- Zero register:
  - wr1 to addr 0 with 0xFFFFFFFF, plus iss_en to addr 0 -> rd_data_a(0)=0, rd_busy_a=0, pending_cnt unchanged.
- Scoreboard lifecycle:
  - Issue r9 -> next cycle rd_busy_a(9)=1, pending_cnt=1.
  - wr1 writes r9 with 0xAB -> rd_busy_a=0 that same cycle, data=0xAB.
  - Issue r9 and wr0 writes r9 in the same cycle -> r9 remains pending.
- Flush:
  - Issue r1, r2, r3 on consecutive cycles -> pending_cnt=3.
  - flush=1 together with iss_en to r4 -> next cycle pending_cnt=0 and r4 not pending.

Source files
------------

// File: rtl/mips_regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_regfile_sb_if
//  Description : Bundles the read, dual-writeback, issue and status signals
//                exchanged between the pipeline and the scoreboarded
//                register file.
//  Revision    : 1.0  initial release
// ============================================================================
interface mips_regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Decode-side read ports
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_busy_a;
    logic              rd_busy_b;

    // ALU writeback
    logic              wr0_en;
    logic [ADDR_W-1:0] wr0_addr;
    logic [DATA_W-1:0] wr0_data;

    // Load writeback
    logic              wr1_en;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr1_data;

    // Issue marking and flush
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              flush;

    // Status
    logic [ADDR_W:0]   pending_cnt;
    logic              wr_conflict;

    // Pipeline side: drives addresses, writes and issues
    modport master (
        output rd_addr_a, rd_addr_b,
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output iss_en, iss_addr, flush,
        input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
        input  pending_cnt, wr_conflict
    );

    // Register file side
    modport slave (
        input  rd_addr_a, rd_addr_b,
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  iss_en, iss_addr, flush,
        output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
        output pending_cnt, wr_conflict
    );
endinterface
`default_nettype wire

// File: rtl/mips_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : mips_regfile_sb
//  Description : Two-write / two-read MIPS register file with write-through
//                bypass, per-register pending scoreboard for RAW hazard
//                detection, pending popcount and a same-target write
//                conflict pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    mips_regfile_sb_if.slave     bus
);
    localparam int c_NREG = 2 ** ADDR_W;
    localparam bit c_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0] r_regs [c_NREG];
    logic [c_NREG-1:0] r_pending;
    logic              r_conflict;

    // Per-register decode of both write ports and the issue port. Hits on a
    // hardwired zero register are suppressed here so nothing downstream has
    // to special-case it.
    logic [c_NREG-1:0] w_wr0_hit;
    logic [c_NREG-1:0] w_wr1_hit;
    logic [c_NREG-1:0] w_iss_hit;
    logic [c_NREG-1:0] w_pend_nxt;

    logic [DATA_W-1:0] w_rd_data_a;
    logic [DATA_W-1:0] w_rd_data_b;
    logic              w_rd_busy_a;
    logic              w_rd_busy_b;
    logic [ADDR_W:0]   w_pend_cnt;
    logic              w_conflict;
    logic              w_zero_a;
    logic              w_zero_b;

    for (genvar g = 0; g < c_NREG; g++) begin : g_dec
        localparam bit c_HARD = c_ZERO && (g == 0);

        assign w_wr0_hit[g] = !c_HARD && bus.wr0_en && (bus.wr0_addr == ADDR_W'(g));
        assign w_wr1_hit[g] = !c_HARD && bus.wr1_en && (bus.wr1_addr == ADDR_W'(g));
        assign w_iss_hit[g] = !c_HARD && bus.iss_en && (bus.iss_addr == ADDR_W'(g));

        // Flush beats everything; a same-cycle issue is younger than the
        // writeback, so its set beats the writeback clear.
        assign w_pend_nxt[g] = bus.flush                  ? 1'b0 :
                               w_iss_hit[g]               ? 1'b1 :
                               (w_wr0_hit[g] || w_wr1_hit[g]) ? 1'b0 :
                               r_pending[g];
    end

    assign w_zero_a   = c_ZERO && (bus.rd_addr_a == '0);
    assign w_zero_b   = c_ZERO && (bus.rd_addr_b == '0);
    assign w_conflict = bus.wr0_en && bus.wr1_en &&
                        (bus.wr0_addr == bus.wr1_addr) &&
                        !(c_ZERO && (bus.wr0_addr == '0));

    // Register array update; load writeback lands last so it wins a collision
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_NREG; i++) begin
                if (w_wr1_hit[i]) begin
                    r_regs[i] <= bus.wr1_data;
                end else if (w_wr0_hit[i]) begin
                    r_regs[i] <= bus.wr0_data;
                end
            end
        end
    end

    // Scoreboard and conflict pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending  <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_pending  <= w_pend_nxt;
            r_conflict <= w_conflict;
        end
    end

    // Read port A: stored value overridden by same-cycle writebacks (wr1 last)
    always_comb begin
        w_rd_data_a = r_regs[bus.rd_addr_a];
        if (w_wr0_hit[bus.rd_addr_a]) begin
            w_rd_data_a = bus.wr0_data;
        end
        if (w_wr1_hit[bus.rd_addr_a]) begin
            w_rd_data_a = bus.wr1_data;
        end
        if (!reset || w_zero_a) begin
            w_rd_data_a = '0;
        end
    end

    // Read port B: same bypass structure as port A
    always_comb begin
        w_rd_data_b = r_regs[bus.rd_addr_b];
        if (w_wr0_hit[bus.rd_addr_b]) begin
            w_rd_data_b = bus.wr0_data;
        end
        if (w_wr1_hit[bus.rd_addr_b]) begin
            w_rd_data_b = bus.wr1_data;
        end
        if (!reset || w_zero_b) begin
            w_rd_data_b = '0;
        end
    end

    // Busy: pending and not being resolved by a writeback this very cycle
    always_comb begin
        w_rd_busy_a = reset && !w_zero_a && r_pending[bus.rd_addr_a] &&
                      !w_wr0_hit[bus.rd_addr_a] && !w_wr1_hit[bus.rd_addr_a];
        w_rd_busy_b = reset && !w_zero_b && r_pending[bus.rd_addr_b] &&
                      !w_wr0_hit[bus.rd_addr_b] && !w_wr1_hit[bus.rd_addr_b];
    end

    // Popcount of the pending vector; width holds NREG without wrapping
    always_comb begin
        w_pend_cnt = '0;
        for (int i = 0; i < c_NREG; i++) begin
            if (!(c_ZERO && i == 0)) begin
                w_pend_cnt = w_pend_cnt + (ADDR_W + 1)'(r_pending[i]);
            end
        end
    end

    assign bus.rd_data_a   = w_rd_data_a;
    assign bus.rd_data_b   = w_rd_data_b;
    assign bus.rd_busy_a   = w_rd_busy_a;
    assign bus.rd_busy_b   = w_rd_busy_b;
    assign bus.pending_cnt = w_pend_cnt;
    assign bus.wr_conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_regfile_sb
//  Description : Self-checking bench for mips_regfile_sb: directed vector
//                table, multi-cycle corner sequences and a randomized run
//                against a behavioural register/scoreboard model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mips_regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          w0e; logic [AW-1:0] w0a; logic [DW-1:0] w0d;
        logic          w1e; logic [AW-1:0] w1a; logic [DW-1:0] w1d;
        logic          ie;  logic [AW-1:0] ia;  logic          fl;
        logic [AW-1:0] ra;  logic [AW-1:0] rb;
        logic [DW-1:0] ea;  logic [DW-1:0] eb;
        logic          eba; logic          ebb;
        logic [AW:0]   ec;  logic          ecf;
    } vec_t;

    vec_t tbl [17];

    // Behavioural model: architectural register contents and pending set
    logic [DW-1:0] m_reg  [32];
    bit            m_pend [32];
    bit            m_conf;

    function automatic vec_t mk(
        input logic w0e, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
        input logic w1e, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
        input logic ie, input logic [AW-1:0] ia, input logic fl,
        input logic [AW-1:0] ra, input logic [AW-1:0] rb,
        input logic [DW-1:0] ea, input logic [DW-1:0] eb,
        input logic eba, input logic ebb, input logic [AW:0] ec, input logic ecf);
        vec_t v;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.ie = ie; v.ia = ia; v.fl = fl; v.ra = ra; v.rb = rb;
        v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb; v.ec = ec; v.ecf = ecf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w0e, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
                         input logic w1e, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
                         input logic ie, input logic [AW-1:0] ia, input logic fl,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        bus.wr0_en = w0e; bus.wr0_addr = w0a; bus.wr0_data = w0d;
        bus.wr1_en = w1e; bus.wr1_addr = w1a; bus.wr1_data = w1d;
        bus.iss_en = ie;  bus.iss_addr = ia;  bus.flush    = fl;
        bus.rd_addr_a = ra; bus.rd_addr_b = rb;
    endtask

    task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, ra, rb);
    endtask

    // Value a reader must see: the register as it will stand after this
    // cycle's writebacks land (register 0 is always zero).
    function automatic logic [DW-1:0] m_view(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = m_reg[a];
        if (bus.wr0_en && bus.wr0_addr == a) v = bus.wr0_data;
        if (bus.wr1_en && bus.wr1_addr == a) v = bus.wr1_data;
        if (a == 0) v = '0;
        return v;
    endfunction

    function automatic logic m_busy(input logic [AW-1:0] a);
        logic written;
        written = (bus.wr0_en && bus.wr0_addr == a) || (bus.wr1_en && bus.wr1_addr == a);
        return (a != 0) && m_pend[a] && !written;
    endfunction

    function automatic logic [AW:0] m_count();
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        return (AW + 1)'(c);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 0;
        end
        m_conf = 0;
    endtask

    // Apply the clock edge to the model using the inputs currently driven
    task automatic m_edge();
        if (bus.wr0_en && bus.wr0_addr != 0) m_reg[bus.wr0_addr] = bus.wr0_data;
        if (bus.wr1_en && bus.wr1_addr != 0) m_reg[bus.wr1_addr] = bus.wr1_data;
        if (bus.flush) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 0;
        end else begin
            if (bus.wr0_en) m_pend[bus.wr0_addr] = 0;
            if (bus.wr1_en) m_pend[bus.wr1_addr] = 0;
            if (bus.iss_en && bus.iss_addr != 0) m_pend[bus.iss_addr] = 1;
        end
        m_conf = bus.wr0_en && bus.wr1_en && (bus.wr0_addr == bus.wr1_addr) && (bus.wr0_addr != 0);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, 31));
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_clear();

        //                w0e w0a w0d           w1e w1a w1d           ie ia fl  ra rb  ea            eb            ba bb cnt cf
        tbl[0]  = mk(1, 7, 32'h12345678, 0, 0, 32'h0,        0, 0, 0,  7, 0,  32'h12345678, 32'h0,        0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0,  7, 3,  32'h12345678, 32'h0,        0, 0, 0, 0);
        tbl[2]  = mk(1, 3, 32'h11,       1, 3, 32'h22,       0, 0, 0,  7, 3,  32'h12345678, 32'h22,       0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0,  7, 3,  32'h12345678, 32'h22,       0, 0, 0, 1);
        tbl[4]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0,  3, 3,  32'h22,       32'h22,       0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 32'h0,        1, 0, 32'hFFFFFFFF, 1, 0, 0,  0, 7,  32'h0,        32'h12345678, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 9, 0,  0, 9,  32'h0,        32'h0,        0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0,  9, 0,  32'h0,        32'h0,        1, 0, 1, 0);
        tbl[8]  = mk(0, 0, 32'h0,        1, 9, 32'hAB,       0, 0, 0,  9, 9,  32'hAB,       32'hAB,       0, 0, 1, 0);
        tbl[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0,  9, 0,  32'hAB,       32'h0,        0, 0, 0, 0);
        tbl[10] = mk(1, 9, 32'hCD,       0, 0, 32'h0,        1, 9, 0,  9, 9,  32'hCD,       32'hCD,       0, 0, 0, 0);
        tbl[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0,  9, 9,  32'hCD,       32'hCD,       1, 1, 1, 0);
        tbl[12] = mk(1, 9, 32'h55,       0, 0, 32'h0,        1, 1, 0,  9, 1,  32'h55,       32'h0,        0, 0, 1, 0);
        tbl[13] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 2, 0,  1, 9,  32'h0,        32'h55,       1, 0, 1, 0);
        tbl[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 3, 0,  1, 2,  32'h0,        32'h0,        1, 1, 2, 0);
        tbl[15] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 4, 1,  3, 4,  32'h22,       32'h0,        1, 0, 3, 0);
        tbl[16] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0,  4, 3,  32'h0,        32'h22,       0, 0, 0, 0);

        // Power-on reset
        reset = 1'b0;
        idle(5, 9);
        repeat (3) @(posedge clk);
        #3;
        chk("por_rd_a", bus.rd_data_a, 0);
        chk("por_busy_a", 32'(bus.rd_busy_a), 0);
        chk("por_cnt", 32'(bus.pending_cnt), 0);
        chk("por_conf", 32'(bus.wr_conflict), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].w0e, tbl[i].w0a, tbl[i].w0d, tbl[i].w1e, tbl[i].w1a, tbl[i].w1d,
                  tbl[i].ie, tbl[i].ia, tbl[i].fl, tbl[i].ra, tbl[i].rb);
            #3;
            chk($sformatf("tbl%0d_rd_a", i), bus.rd_data_a, tbl[i].ea);
            chk($sformatf("tbl%0d_rd_b", i), bus.rd_data_b, tbl[i].eb);
            chk($sformatf("tbl%0d_busy_a", i), 32'(bus.rd_busy_a), 32'(tbl[i].eba));
            chk($sformatf("tbl%0d_busy_b", i), 32'(bus.rd_busy_b), 32'(tbl[i].ebb));
            chk($sformatf("tbl%0d_cnt", i), 32'(bus.pending_cnt), 32'(tbl[i].ec));
            chk($sformatf("tbl%0d_conf", i), 32'(bus.wr_conflict), 32'(tbl[i].ecf));
            @(posedge clk); #1;
        end

        // Back-to-back conflicts, then a collision on the hardwired register
        drive(1, 10, 32'h1, 1, 10, 32'h2, 0, 0, 0, 10, 11);
        #3; chk("cf_a_conf", 32'(bus.wr_conflict), 0);
        @(posedge clk); #1;
        drive(1, 11, 32'h3, 1, 11, 32'h4, 0, 0, 0, 10, 11);
        #3; chk("cf_b_conf", 32'(bus.wr_conflict), 1);
        chk("cf_b_rd_b", bus.rd_data_b, 32'h4);
        @(posedge clk); #1;
        drive(1, 0, 32'h5, 1, 0, 32'h6, 0, 0, 0, 10, 11);
        #3; chk("cf_c_conf", 32'(bus.wr_conflict), 1);
        @(posedge clk); #1;
        idle(10, 11);
        #3; chk("cf_d_conf", 32'(bus.wr_conflict), 0);
        chk("cf_d_rd_a", bus.rd_data_a, 32'h2);
        chk("cf_d_rd_b", bus.rd_data_b, 32'h4);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a cycle
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 0, 5, 0);
        @(posedge clk); #1;
        idle(5, 0);
        #3;
        chk("ar_pre_rd_a", bus.rd_data_a, 32'hDEADBEEF);
        chk("ar_pre_busy_a", 32'(bus.rd_busy_a), 1);
        chk("ar_pre_cnt", 32'(bus.pending_cnt), 1);
        reset = 1'b0;
        #1;
        chk("ar_rd_a", bus.rd_data_a, 0);
        chk("ar_busy_a", 32'(bus.rd_busy_a), 0);
        chk("ar_cnt", 32'(bus.pending_cnt), 0);
        @(posedge clk); #3;
        reset = 1'b1;
        m_clear();
        @(posedge clk); #1;

        // Randomized run against the model
        for (int c = 0; c < 800; c++) begin
            drive(($urandom_range(0, 1) == 1), rnd_addr(), $urandom(),
                  ($urandom_range(0, 1) == 1), rnd_addr(), $urandom(),
                  ($urandom_range(0, 9) < 4), rnd_addr(), ($urandom_range(0, 19) == 0),
                  rnd_addr(), rnd_addr());
            #3;
            chk("rnd_rd_a", bus.rd_data_a, m_view(bus.rd_addr_a));
            chk("rnd_rd_b", bus.rd_data_b, m_view(bus.rd_addr_b));
            chk("rnd_busy_a", 32'(bus.rd_busy_a), 32'(m_busy(bus.rd_addr_a)));
            chk("rnd_busy_b", 32'(bus.rd_busy_b), 32'(m_busy(bus.rd_addr_b)));
            chk("rnd_cnt", 32'(bus.pending_cnt), 32'(m_count()));
            chk("rnd_conf", 32'(bus.wr_conflict), 32'(m_conf));
            @(posedge clk);
            m_edge();
            #1;
        end

        idle(0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
